output_drain_buffer: RTL and testbench

OUTPUT_DRAIN_BUFFER -- requirements
Module: output_drain_buffer

---
 rtl/output_drain_buffer_pkg.sv | 10 +
 rtl/column_store.sv | 46 ++++
 rtl/output_drain_buffer.sv | 132 +++++++++++++
 tb/tb_output_drain_buffer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/output_drain_buffer_pkg.sv
// Shared configuration defaults for the systolic result path.
// The drain buffer and its column stores import these values.
package output_drain_buffer_pkg;

    localparam int ARRAYWIDTH_DEF = 16;
    localparam int DATASIZE_DEF   = 32;
    localparam int DSP_DELAY      = 3;
    localparam int DEPTH_DEF      = 16;

endpackage

// File: rtl/column_store.sv
// One column of result storage: a write counter that doubles as the row
// pointer, and a registered read port addressed by the drain logic.
module column_store
    import output_drain_buffer_pkg::*;
#(
    parameter int DATASIZE = DATASIZE_DEF,
    parameter int DEPTH    = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       wr_req,
    input  logic [DATASIZE-1:0]        wr_data,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [DATASIZE-1:0]        rd_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DATASIZE-1:0] mem [DEPTH];
    logic [CW-1:0]       wr_cnt;
    logic                we;

    // Writes beyond DEPTH are dropped, so a column never wraps within a pass.
    assign we = wr_req && (wr_cnt != FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt <= '0;
        end else if (clr) begin
            wr_cnt <= '0;
        end else if (we) begin
            wr_cnt <= wr_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_cnt[AW-1:0]] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/output_drain_buffer.sv
// Captures the skewed result stream of a systolic array column by column,
// then drains deskewed rows over a valid/ready handshake.
module output_drain_buffer
    import output_drain_buffer_pkg::*;
#(
    parameter int ARRAYWIDTH = ARRAYWIDTH_DEF,
    parameter int DATASIZE   = DATASIZE_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int SKEW       = DSP_DELAY
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           load_en,
    input  logic [ARRAYWIDTH*DATASIZE-1:0] in_res,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ARRAYWIDTH*DATASIZE-1:0] out_res,
    output logic                           out_last,
    output logic                           busy,
    output logic                           overflow
);

    localparam int T_MAX = (ARRAYWIDTH - 1) * SKEW + DEPTH;
    localparam int TW    = $clog2(T_MAX + 1);
    localparam int RW    = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   t_q;
    logic [RW-1:0]   rd_row_q, rd_row_d;
    logic            overflow_q;
    logic            arm, cap, clr, last_wr;
    logic [ARRAYWIDTH-1:0] wr_req;

    assign arm = (state_q == IDLE) && start;
    // A start+load_en cycle in IDLE is already step t=0 of the pass.
    assign cap = load_en && ((state_q == CAPTURE) || arm);
    assign clr = (state_q != CAPTURE) && !cap;
    // Last column's DEPTH-th write lands on the final step before T_MAX.
    assign last_wr = cap && (t_q == TW'(T_MAX - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            t_q <= '0;
        end else if (cap) begin
            if (t_q != TW'(T_MAX)) begin
                t_q <= t_q + 1'b1;
            end
        end else if (state_q != CAPTURE) begin
            t_q <= '0;
        end
    end

    always_comb begin
        state_d  = state_q;
        rd_row_d = rd_row_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CAPTURE;
                end
                rd_row_d = '0;
            end
            CAPTURE: begin
                if (last_wr) begin
                    state_d = DRAIN;
                end
                rd_row_d = '0;
            end
            DRAIN: begin
                if (out_ready) begin
                    if (rd_row_q == RW'(DEPTH - 1)) begin
                        state_d  = IDLE;
                        rd_row_d = '0;
                    end else begin
                        rd_row_d = rd_row_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                rd_row_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rd_row_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_row_q <= rd_row_d;
            if (arm) begin
                overflow_q <= 1'b0;
            end else if (load_en && (state_q != CAPTURE)) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Stores read the next row ahead so out_res is registered yet on time.
    for (genvar i = 0; i < ARRAYWIDTH; i++) begin : g_col
        assign wr_req[i] = cap && (t_q >= TW'(i * SKEW));

        column_store #(
            .DATASIZE (DATASIZE),
            .DEPTH    (DEPTH)
        ) u_col (
            .clk     (clk),
            .rst     (rst),
            .clr     (clr),
            .wr_req  (wr_req[i]),
            .wr_data (in_res[i*DATASIZE +: DATASIZE]),
            .rd_addr (rd_row_d),
            .rd_data (out_res[i*DATASIZE +: DATASIZE])
        );
    end

    assign out_valid = (state_q == DRAIN);
    assign out_last  = out_valid && (rd_row_q == RW'(DEPTH - 1));
    assign busy      = (state_q != IDLE);
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_output_drain_buffer.sv
// Directed bench for output_drain_buffer: capture, deskew, drain,
// back-pressure, reset mid-pass, overflow and stray start handling.
module tb_output_drain_buffer;

    localparam int AW = 4;
    localparam int DS = 8;
    localparam int DP = 4;
    localparam int SK = 2;
    localparam int NLOAD = (AW - 1) * SK + DP;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              load_en;
    logic [AW*DS-1:0]  in_res;
    logic              out_valid;
    logic              out_ready;
    logic [AW*DS-1:0]  out_res;
    logic              out_last;
    logic              busy;
    logic              overflow;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    output_drain_buffer #(
        .ARRAYWIDTH (AW),
        .DATASIZE   (DS),
        .DEPTH      (DP),
        .SKEW       (SK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .load_en   (load_en),
        .in_res    (in_res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_last  (out_last),
        .busy      (busy),
        .overflow  (overflow)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Word k of column i is 16*i+k; slices not yet/no longer live carry 0xEE.
    function automatic logic [AW*DS-1:0] stream(input int t);
        logic [AW*DS-1:0] v;
        v = '0;
        for (int i = 0; i < AW; i++) begin
            if (t >= i * SK && t - i * SK < DP)
                v[i*DS +: DS] = DS'(16 * i + t - i * SK);
            else
                v[i*DS +: DS] = 8'hEE;
        end
        return v;
    endfunction

    function automatic logic [AW*DS-1:0] row(input int r);
        logic [AW*DS-1:0] v;
        for (int i = 0; i < AW; i++)
            v[i*DS +: DS] = DS'(16 * i + r);
        return v;
    endfunction

    // Starts a pass and feeds the full skewed stream.
    task automatic capture(input bit gapped, input bit with_load,
                           input string nm);
        int t;
        int cyc;
        t = 0;
        cyc = 0;
        start = 1'b1;
        load_en = with_load;
        in_res = with_load ? stream(0) : {AW*DS{1'b1}};
        if (with_load) t = 1;
        step();
        start = 1'b0;
        n_chk++;
        if (busy !== 1'b1 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL %s arm: busy=%b ovf=%b required 1/0",
                     nm, busy, overflow);
        end
        while (t < NLOAD && cyc < 100) begin
            n_chk++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL %s early_drain at t=%0d: out_valid=%b required 0",
                         nm, t, out_valid);
            end
            if (gapped && cyc[0]) begin
                load_en = 1'b0;
                in_res = $urandom;
            end else begin
                load_en = 1'b1;
                in_res = stream(t);
                t++;
            end
            cyc++;
            step();
        end
        load_en = 1'b0;
        in_res = '0;
        n_chk++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s drain_entry: out_valid=%b busy=%b required 1/1",
                     nm, out_valid, busy);
        end
    endtask

    // mode 0: ready always; 1: ready 1,0,0 repeating; 2: stray start on row 1.
    task automatic drain(input int mode, input string nm);
        int rows;
        int cyc;
        rows = 0;
        cyc = 0;
        while (rows < DP && cyc < 40) begin
            out_ready = (mode == 1) ? (cyc % 3 == 0) : 1'b1;
            start = (mode == 2 && rows == 1);
            n_chk++;
            if (out_valid !== 1'b1 || out_res !== row(rows)
                || out_last !== (rows == DP - 1)) begin
                n_fail++;
                $display("FAIL %s row%0d cyc%0d: v=%b res=%h last=%b required 1 %h %b",
                         nm, rows, cyc, out_valid, out_res, out_last,
                         row(rows), rows == DP - 1);
            end
            if (out_ready) rows++;
            cyc++;
            step();
        end
        start = 1'b0;
        out_ready = 1'b0;
        n_chk++;
        if (rows != DP || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s drain_end: beats=%0d v=%b busy=%b required %0d 0 0",
                     nm, rows, out_valid, busy, DP);
        end
        if (mode == 0) begin
            n_chk++;
            if (cyc != DP) begin
                n_fail++;
                $display("FAIL %s drain_cycles: %0d required %0d", nm, cyc, DP);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        load_en = 1'b0;
        out_ready = 1'b0;
        in_res = '0;
        step();
        step();
        n_chk++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0
            || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: busy=%b v=%b last=%b ovf=%b required 0000",
                     busy, out_valid, out_last, overflow);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        capture(1'b0, 1'b0, "basic");
        drain(0, "basic");
    endtask

    task automatic test_gapped();
        capture(1'b1, 1'b0, "gapped");
        drain(0, "gapped");
    endtask

    task automatic test_backpressure();
        capture(1'b0, 1'b0, "bp");
        drain(1, "bp");
    endtask

    task automatic test_reset_midcapture();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 0; t < 5; t++) begin
            load_en = 1'b1;
            in_res = stream(t);
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        load_en = 1'b0;
        n_chk++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: busy=%b v=%b required 0 0", busy, out_valid);
        end
        step();
        capture(1'b0, 1'b1, "rst_new_pass");
        drain(0, "rst_new_pass");
    endtask

    task automatic test_overflow();
        load_en = 1'b1;
        in_res = {AW*DS{1'b1}};
        step();
        load_en = 1'b0;
        step();
        n_chk++;
        if (overflow !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_set: ovf=%b busy=%b required 1 0", overflow, busy);
        end
        capture(1'b0, 1'b0, "ovf_clear");
        drain(0, "ovf_clear");
    endtask

    task automatic test_start_in_drain();
        capture(1'b1, 1'b0, "start_drain");
        drain(2, "start_drain");
        step();
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_drain idle: busy=%b required 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_backpressure();
        test_reset_midcapture();
        test_overflow();
        test_start_in_drain();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
